// File: rtl/banco_registro_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : banco_registro_multi
// Description : Parametrised register bank with N read ports, optional
//               registered reads with write-first bypass, and a sequenced
//               bulk clear that zeroes one entry per cycle while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module banco_registro_multi #(
  parameter int BIT_ADDR  = 3,
  parameter int BIT_DATO  = 8,
  parameter int N_RD      = 2,
  parameter int READ_SYNC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [BIT_ADDR-1:0]      wr_addr,
  input  logic [BIT_DATO-1:0]      wr_data,
  output logic                     wr_ack,
  input  logic                     clr,
  output logic                     busy,
  input  logic [N_RD*BIT_ADDR-1:0] rd_addr,
  output logic [N_RD*BIT_DATO-1:0] rd_data
);

  localparam int                  NREG     = 2**BIT_ADDR;
  localparam logic [BIT_ADDR-1:0] PTR_LAST = BIT_ADDR'(NREG - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              state_q;
  logic [BIT_ADDR-1:0] ptr_q;
  logic [BIT_DATO-1:0] mem_q [NREG];
  logic                wr_ack_q;
  logic                wr_accept;

  // Writes are only taken while the clear sequencer is idle; others are dropped.
  assign wr_accept = wr_en && (state_q == S_IDLE);
  assign busy      = (state_q == S_CLEAR);
  assign wr_ack    = wr_ack_q;

  // Clear sequencer: walks the pointer over every entry once, and acks writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_accept;
      case (state_q)
        S_IDLE: begin
          if (clr) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
          end
        end
        S_CLEAR: begin
          ptr_q <= ptr_q + BIT_ADDR'(1);
          if (ptr_q == PTR_LAST) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage array: accepted writes and clear-pointer zeroing never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_accept) begin
        mem_q[wr_addr] <= wr_data;
      end
      if (state_q == S_CLEAR) begin
        mem_q[ptr_q] <= '0;
      end
    end
  end

  generate
    if (READ_SYNC != 0) begin : g_rd_sync
      for (genvar k = 0; k < N_RD; k++) begin : g_port
        logic [BIT_ADDR-1:0] addr;
        logic [BIT_DATO-1:0] rd_q;

        assign addr = rd_addr[k*BIT_ADDR +: BIT_ADDR];

        // Registered read: same-cycle write wins, then the entry being cleared.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            rd_q <= '0;
          end else if (wr_accept && (wr_addr == addr)) begin
            rd_q <= wr_data;
          end else if ((state_q == S_CLEAR) && (ptr_q == addr)) begin
            rd_q <= '0;
          end else begin
            rd_q <= mem_q[addr];
          end
        end

        assign rd_data[k*BIT_DATO +: BIT_DATO] = rd_q;
      end
    end else begin : g_rd_comb
      for (genvar k = 0; k < N_RD; k++) begin : g_port
        assign rd_data[k*BIT_DATO +: BIT_DATO] = mem_q[rd_addr[k*BIT_ADDR +: BIT_ADDR]];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_banco_registro_multi.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for banco_registro_multi: one combinational-read and one
// registered-read instance share stimulus and are checked against a model.
module tb_banco_registro_multi;

  localparam int A    = 3;
  localparam int D    = 8;
  localparam int NR   = 2;
  localparam int NREG = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic            clr = 1'b0;
  logic [A-1:0]    wr_addr = '0;
  logic [D-1:0]    wr_data = '0;
  logic [NR*A-1:0] rd_addr = '0;
  logic            ack_c, ack_s, busy_c, busy_s;
  logic [NR*D-1:0] rd_c, rd_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  banco_registro_multi #(.BIT_ADDR(A), .BIT_DATO(D), .N_RD(NR), .READ_SYNC(0)) u_comb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(ack_c), .clr(clr), .busy(busy_c), .rd_addr(rd_addr), .rd_data(rd_c)
  );

  banco_registro_multi #(.BIT_ADDR(A), .BIT_DATO(D), .N_RD(NR), .READ_SYNC(1)) u_sync (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(ack_s), .clr(clr), .busy(busy_s), .rd_addr(rd_addr), .rd_data(rd_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: array contents, remaining-clear bookkeeping, expected outputs.
  logic [D-1:0] m_mem [NREG];
  logic [D-1:0] m_rs  [NR];
  bit           m_busy;
  int           m_idx;
  bit           m_ack;

  always @(posedge clk or negedge rst) begin : model
    bit acc;
    int a;
    if (!rst) begin
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      for (int k = 0; k < NR; k++) m_rs[k] = '0;
      m_busy = 1'b0;
      m_idx  = 0;
      m_ack  = 1'b0;
    end else begin
      acc = wr_en && !m_busy;
      for (int k = 0; k < NR; k++) begin
        a = int'(rd_addr[k*A +: A]);
        if (acc && int'(wr_addr) == a)    m_rs[k] = wr_data;
        else if (m_busy && m_idx == a)    m_rs[k] = '0;
        else                              m_rs[k] = m_mem[a];
      end
      if (acc) m_mem[wr_addr] = wr_data;
      if (m_busy) begin
        m_mem[m_idx] = '0;
        m_idx++;
        if (m_idx == NREG) begin
          m_busy = 1'b0;
          m_idx  = 0;
        end
      end else if (clr) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end
      m_ack = acc;
    end
  end

  // Every cycle, on the falling edge, both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < NR; k++) begin
      chk("rd_comb", rd_c[k*D +: D], m_mem[rd_addr[k*A +: A]]);
      chk("rd_sync", rd_s[k*D +: D], m_rs[k]);
    end
    chk("busy_comb", busy_c, m_busy);
    chk("busy_sync", busy_s, m_busy);
    chk("ack_comb", ack_c, m_ack);
    chk("ack_sync", ack_s, m_ack);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [A-1:0] ad, input logic [D-1:0] dt);
    wr_en = 1'b1; wr_addr = ad; wr_data = dt;
    step();
    chk("wr_ack_pulse", ack_c, 1'b1);
    wr_en = 1'b0;
    step();
    chk("wr_ack_once", ack_c, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_c && n < 20) begin
      step();
      n++;
    end
    chk("idle_timeout", busy_c, 1'b0);
  endtask

  initial begin : stim
    int n;
    #1 rst = 1'b0;
    step(); step();
    chk("rst_busy", busy_c, 1'b0);
    chk("rst_ack", ack_s, 1'b0);
    chk("rst_rd_sync", rd_s, 16'h0000);
    rst = 1'b1;

    // Reset readback on every address, both ports
    for (int a = 0; a < NREG; a++) begin
      rd_addr = {2{3'(a)}};
      #1 chk("rb_comb", rd_c, 16'h0000);
      step();
      chk("rb_sync", rd_s, 16'h0000);
    end

    // Two-port write/read
    wr(3'd3, 8'hA5);
    wr(3'd6, 8'h3C);
    rd_addr = {3'd6, 3'd3};
    #1 chk("two_port_comb", rd_c, 16'h3CA5);
    step();
    chk("two_port_sync", rd_s, 16'h3CA5);

    // Registered-read write-first bypass
    rd_addr = {3'd2, 3'd5};
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h77;
    step();
    chk("bypass_sync", rd_s, 16'h0077);
    wr_en = 1'b0;
    step();

    // Bulk clear with mid-clear snapshot
    for (int i = 0; i < NREG; i++) wr(3'(i), 8'(8'h10 + i));
    rd_addr = {3'd6, 3'd2};
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_busy_rise", busy_c, 1'b1);
    n = 0;
    while (busy_c && n < 20) begin
      if (n == 4) begin
        chk("mid_clear_comb", rd_c, 16'h1600);
        chk("mid_clear_sync", rd_s, 16'h1600);
      end
      step();
      n++;
    end
    chk("busy_len", n, 8);
    for (int a = 0; a < NREG; a++) begin
      rd_addr = {2{3'(a)}};
      #1 chk("post_clear", rd_c, 16'h0000);
    end

    // Write held through a clear
    clr = 1'b1;
    step();
    clr = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hFF;
    n = 0;
    while (busy_c && n < 20) begin
      chk("no_ack_busy", ack_c, 1'b0);
      step();
      n++;
    end
    chk("busy_len2", n, 8);
    chk("ack_not_yet", ack_c, 1'b0);
    step();
    chk("ack_after_busy", ack_c, 1'b1);
    wr_en = 1'b0;
    rd_addr = {3'd1, 3'd1};
    #1 chk("held_write_data", rd_c, 16'hFFFF);
    step();

    // clr and write in the same cycle
    rd_addr = {3'd0, 3'd0};
    clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h55;
    step();
    clr = 1'b0; wr_en = 1'b0;
    chk("simul_ack", ack_c, 1'b1);
    chk("simul_busy", busy_c, 1'b1);
    chk("simul_data", rd_c, 16'h5555);
    step();
    chk("simul_cleared", rd_c, 16'h0000);
    wait_idle();

    // Reset in the middle of a clear, then restart from pointer 0
    wr(3'd2, 8'h42);
    wr(3'd7, 8'h99);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step(); step();
    rst = 1'b0;
    #1 chk("abort_busy_c", busy_c, 1'b0);
    chk("abort_busy_s", busy_s, 1'b0);
    chk("abort_rd_sync", rd_s, 16'h0000);
    for (int a = 0; a < NREG; a++) begin
      rd_addr = {2{3'(a)}};
      #1 chk("abort_entries", rd_c, 16'h0000);
    end
    step();
    rst = 1'b1;
    wr(3'd0, 8'h20);
    wr(3'd1, 8'h21);
    rd_addr = {3'd1, 3'd0};
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("restart_ptr0", rd_c, 16'h2100);
    wait_idle();

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 400; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom);
      wr_data = 8'($urandom);
      clr     = ($urandom_range(0, 15) == 0);
      rd_addr = 6'($urandom);
      step();
    end
    wr_en = 1'b0;
    clr   = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
